mem_bus_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between the CPU instruction-fetch port and the CPU data port.
- It is a per-transaction FSM with a ready handshake, fixed data-over-instruction priority and a watchdog timeout.
- Sits between the CPU's IAB/IDB and DAB/DDB/MemRead/MemWrite interfaces and the system memory.
- Returned data and completion pulses are registered.

---
 rtl/mem_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-ported, variable-latency memory between
// the CPU instruction-fetch port and the CPU data port. One transaction at a
// time, data has fixed priority over instruction fetch, and a watchdog
// aborts any access whose memory never answers.
module mem_bus_arbiter #(
    parameter int WORD      = 64,
    parameter int INST_SIZE = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req,
    input  logic [WORD-1:0]      i_addr,
    output logic [INST_SIZE-1:0] i_rdata,
    output logic                 i_valid,
    input  logic                 d_rd,
    input  logic                 d_wr,
    input  logic [WORD-1:0]      d_addr,
    input  logic [WORD-1:0]      d_wdata,
    output logic [WORD-1:0]      d_rdata,
    output logic                 d_valid,
    output logic [WORD-1:0]      mem_addr,
    output logic [WORD-1:0]      mem_wdata,
    output logic                 mem_re,
    output logic                 mem_we,
    input  logic [WORD-1:0]      mem_rdata,
    input  logic                 mem_ready,
    output logic                 bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // Last counter value still waiting; one more unanswered cycle aborts.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;

    state_t                 state_r,     state_s;
    logic [CW-1:0]          cnt_r,       cnt_s;
    logic [WORD-1:0]        mem_addr_r,  mem_addr_s;
    logic [WORD-1:0]        mem_wdata_r, mem_wdata_s;
    logic                   mem_re_r,    mem_re_s;
    logic                   mem_we_r,    mem_we_s;
    logic [INST_SIZE-1:0]   i_rdata_r,   i_rdata_s;
    logic [WORD-1:0]        d_rdata_r,   d_rdata_s;
    logic                   i_valid_r,   i_valid_s;
    logic                   d_valid_r,   d_valid_s;
    logic                   bus_err_r,   bus_err_s;

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_re_s    = mem_re_r;
        mem_we_s    = mem_we_r;
        i_rdata_s   = i_rdata_r;
        d_rdata_s   = d_rdata_r;
        i_valid_s   = 1'b0;
        d_valid_s   = 1'b0;
        bus_err_s   = bus_err_r;
        case (state_r)
            IDLE: begin
                if (d_rd || d_wr) begin
                    state_s    = DACC;
                    cnt_s      = '0;
                    mem_addr_s = d_addr;
                    if (d_wr) begin
                        // A write wins when both strobes are requested.
                        mem_wdata_s = d_wdata;
                        mem_we_s    = 1'b1;
                        mem_re_s    = 1'b0;
                    end else begin
                        mem_we_s = 1'b0;
                        mem_re_s = 1'b1;
                    end
                    if (d_rd && d_wr) begin
                        bus_err_s = 1'b1;
                    end else begin
                        bus_err_s = bus_err_r;
                    end
                end else if (i_req) begin
                    state_s    = IACC;
                    cnt_s      = '0;
                    mem_addr_s = i_addr;
                    mem_we_s   = 1'b0;
                    mem_re_s   = 1'b1;
                end else begin
                    // mem_ready seen while idle is ignored
                    state_s = IDLE;
                end
            end
            DACC: begin
                if (mem_ready) begin
                    state_s   = IDLE;
                    mem_re_s  = 1'b0;
                    mem_we_s  = 1'b0;
                    d_valid_s = 1'b1;
                    if (mem_we_r) begin
                        d_rdata_s = d_rdata_r;
                    end else begin
                        d_rdata_s = mem_rdata;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_s   = IDLE;
                    mem_re_s  = 1'b0;
                    mem_we_s  = 1'b0;
                    d_valid_s = 1'b1;
                    d_rdata_s = '0;
                    bus_err_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            IACC: begin
                if (mem_ready) begin
                    state_s   = IDLE;
                    mem_re_s  = 1'b0;
                    mem_we_s  = 1'b0;
                    i_valid_s = 1'b1;
                    i_rdata_s = mem_rdata[INST_SIZE-1:0];
                end else if (cnt_r == CNT_LAST) begin
                    state_s   = IDLE;
                    mem_re_s  = 1'b0;
                    mem_we_s  = 1'b0;
                    i_valid_s = 1'b1;
                    i_rdata_s = '0;
                    bus_err_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s  = IDLE;
                mem_re_s = 1'b0;
                mem_we_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any access with no pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_re_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            i_rdata_r   <= '0;
            d_rdata_r   <= '0;
            i_valid_r   <= 1'b0;
            d_valid_r   <= 1'b0;
            bus_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_re_r    <= mem_re_s;
            mem_we_r    <= mem_we_s;
            i_rdata_r   <= i_rdata_s;
            d_rdata_r   <= d_rdata_s;
            i_valid_r   <= i_valid_s;
            d_valid_r   <= d_valid_s;
            bus_err_r   <= bus_err_s;
        end
    end

    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_re    = mem_re_r;
    assign mem_we    = mem_we_r;
    assign i_rdata   = i_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign i_valid   = i_valid_r;
    assign d_valid   = d_valid_r;
    assign bus_err   = bus_err_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a behavioural memory responder with
// programmable wait states plus a transaction-level expectation model.
module tb_mem_bus_arbiter;

    localparam int WORD      = 64;
    localparam int INST_SIZE = 32;
    localparam int TIMEOUT   = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 i_req = 1'b0;
    logic [WORD-1:0]      i_addr = '0;
    logic [INST_SIZE-1:0] i_rdata;
    logic                 i_valid;
    logic                 d_rd = 1'b0;
    logic                 d_wr = 1'b0;
    logic [WORD-1:0]      d_addr = '0;
    logic [WORD-1:0]      d_wdata = '0;
    logic [WORD-1:0]      d_rdata;
    logic                 d_valid;
    logic [WORD-1:0]      mem_addr;
    logic [WORD-1:0]      mem_wdata;
    logic                 mem_re;
    logic                 mem_we;
    logic [WORD-1:0]      mem_rdata = '0;
    logic                 mem_ready = 1'b0;
    logic                 bus_err;

    mem_bus_arbiter #(.WORD(WORD), .INST_SIZE(INST_SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Memory contents seen by the responder, and the bench's expected contents.
    logic [63:0] resp_mem [logic [63:0]];
    logic [63:0] exp_mem  [logic [63:0]];
    int          wait_cfg = 0;
    int          wcnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [63:0] exp_d = '0;
    logic [31:0] exp_i = '0;
    logic        err_exp = 1'b0;

    function automatic logic [63:0] seed_val(input logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [63:0] exp_rd(input logic [63:0] a);
        if (exp_mem.exists(a)) return exp_mem[a];
        return seed_val(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory responder: answers after wait_cfg unready cycles; noise while idle.
    always @(negedge clk) begin
        if (mem_re || mem_we) begin
            if (wcnt == wait_cfg) begin
                mem_ready = 1'b1;
                if (mem_we) resp_mem[mem_addr] = mem_wdata;
                mem_rdata = resp_mem.exists(mem_addr) ? resp_mem[mem_addr] : seed_val(mem_addr);
                wcnt++;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = {$urandom, $urandom};
                wcnt++;
            end
        end else begin
            wcnt = 0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = {$urandom, $urandom};
        end
    end

    // kind: 0 fetch, 1 data read, 2 data write, 3 read+write together
    task automatic drive(input int kind, input logic [63:0] addr, input logic [63:0] wdata);
        if (kind == 0) begin
            i_req = 1'b1; i_addr = addr;
        end else begin
            d_addr = addr; d_wdata = wdata;
            d_rd = (kind == 1 || kind == 3);
            d_wr = (kind >= 2);
            if (kind == 3) err_exp = 1'b1;
        end
    endtask

    // Follow one transaction from its first strobe cycle to its valid pulse.
    task automatic watch(input int kind, input logic [63:0] addr, input logic [63:0] wdata,
                         input int waits);
        int   strobes;
        bit   done;
        bit   wr;
        bit   abort;
        int   exp_n;
        logic [63:0] v;
        wr      = (kind >= 2);
        abort   = (waits >= TIMEOUT);
        exp_n   = abort ? TIMEOUT : waits + 1;
        wait_cfg = waits;
        strobes = 0;
        done    = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (i_valid || d_valid) begin
                done = 1'b1;
                check("valid_port", {62'd0, i_valid, d_valid}, (kind == 0) ? 64'd2 : 64'd1);
                check("strobe_cycles", strobes, exp_n);
                check("strobe_off", {62'd0, mem_re, mem_we}, 64'd0);
                if (abort) err_exp = 1'b1;
                v = exp_rd(addr);
                if (kind == 0) exp_i = abort ? 32'd0 : v[31:0];
                else if (kind == 1) exp_d = abort ? 64'd0 : v;
                else if (abort) exp_d = 64'd0;
                else exp_mem[addr] = wdata;
                check("i_rdata", i_rdata, exp_i);
                check("d_rdata", d_rdata, exp_d);
                check("bus_err", bus_err, err_exp);
                if (kind == 0) i_req = 1'b0;
                else begin d_rd = 1'b0; d_wr = 1'b0; end
            end else if (mem_re || mem_we) begin
                strobes++;
                check("mem_addr", mem_addr, addr);
                check("strobe_dir", {62'd0, mem_re, mem_we}, wr ? 64'd1 : 64'd2);
                if (wr) check("mem_wdata", mem_wdata, wdata);
                // Inputs wander mid-access; the latched values must not follow.
                if (kind == 0) begin
                    i_addr = {$urandom, $urandom};
                    if ($urandom_range(0, 3) == 0) i_req = 1'b0;
                end else begin
                    d_addr = {$urandom, $urandom};
                    d_wdata = {$urandom, $urandom};
                    if ($urandom_range(0, 3) == 0) begin d_rd = 1'b0; d_wr = 1'b0; end
                end
            end else begin
                check("idle_gap", {62'd0, mem_re, mem_we}, wr ? 64'd1 : 64'd2);
            end
        end
        check("hang", done, 64'd1);
        if (!done) begin
            i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] w;
        int          k;
        int          r;
        int          wt;
        exp_mem[64'h40]  = 64'h1234_5678_8B02_0020;
        resp_mem[64'h40] = 64'h1234_5678_8B02_0020;

        #12;
        check("rst_mem_re", mem_re, 64'd0);
        check("rst_mem_we", mem_we, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_valids", {62'd0, i_valid, d_valid}, 64'd0);
        check("rst_bus_err", bus_err, 64'd0);
        check("rst_rdata", d_rdata | {32'd0, i_rdata}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single fetch, two wait states.
        drive(0, 64'h40, 64'd0);
        watch(0, 64'h40, 64'd0, 2);
        check("fetch_word", i_rdata, 64'h8B02_0020);

        // Simultaneous fetch and data read: data first, then the fetch.
        exp_mem.delete(64'h100);
        drive(0, 64'h44, 64'd0);
        drive(1, 64'h100, 64'd0);
        watch(1, 64'h100, 64'd0, 0);
        watch(0, 64'h44, 64'd0, 0);

        // Write with data changing mid-access.
        drive(2, 64'h200, 64'hDEAD_BEEF);
        watch(2, 64'h200, 64'hDEAD_BEEF, 3);
        drive(1, 64'h200, 64'd0);
        watch(1, 64'h200, 64'd0, 1);

        // Boundary: answer on the last allowed cycle completes normally.
        drive(0, 64'h48, 64'd0);
        watch(0, 64'h48, 64'd0, TIMEOUT - 1);

        // Timeout abort, then a normal read still works with bus_err sticky.
        drive(0, 64'h4C, 64'd0);
        watch(0, 64'h4C, 64'd0, TIMEOUT + 5);
        drive(1, 64'h200, 64'd0);
        watch(1, 64'h200, 64'd0, 0);

        // Illegal read+write: a write is done.
        drive(3, 64'h300, 64'hCAFE_F00D_0000_0001);
        watch(3, 64'h300, 64'hCAFE_F00D_0000_0001, 1);
        drive(1, 64'h300, 64'd0);
        watch(1, 64'h300, 64'd0, 0);

        // Reset in the middle of a data access.
        wait_cfg = 10;
        drive(1, 64'h500, 64'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_strobes", {62'd0, mem_re, mem_we}, 64'd0);
        check("arst_addr", mem_addr, 64'd0);
        check("arst_bus_err", bus_err, 64'd0);
        check("arst_data", d_rdata | {32'd0, i_rdata}, 64'd0);
        exp_d = '0; exp_i = '0; err_exp = 1'b0;
        d_rd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("arst_no_valid", {62'd0, i_valid, d_valid}, 64'd0);
        rst_n = 1'b1;
        drive(0, 64'h40, 64'd0);
        watch(0, 64'h40, 64'd0, 0);

        // Randomized traffic over a small address pool.
        for (int n = 0; n < 40; n++) begin
            a = {55'd0, 6'($urandom_range(0, 7)), 3'd0} + 64'h1000;
            w = {$urandom, $urandom};
            r = $urandom_range(0, 9);
            wt = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? TIMEOUT - 1 : TIMEOUT;
            k = $urandom_range(0, 19);
            if (k == 19) k = 3;
            else if (k == 18) k = 4;
            else k = k % 3;
            if (k == 4) begin
                drive(0, a + 64'h800, 64'd0);
                drive(1, a, 64'd0);
                watch(1, a, 64'd0, wt);
                watch(0, a + 64'h800, 64'd0, $urandom_range(0, 2));
            end else begin
                drive(k, a, w);
                watch(k, a, w, wt);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
